// File: rtl/imem_fetch_sequencer.sv
// Fetch-stage controller: owns the PC, drives the instruction-memory address and fills IF/ID.
// Optional performance counters (CycleCount, FetchCount) are enabled by defining FETCH_PERF_CNT_EN.
module imem_fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_0FFC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    output logic [31:0] IfIdInstruction,
    output logic [31:0] IfIdPCPlus4,
    output logic        IfIdValid,
    output logic        Running,
    output logic        Halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] CycleCount,
    output logic [31:0] FetchCount
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;
    logic        r_running;
    logic        r_halted;

    logic [31:0] w_pc_plus4;
    logic        w_is_halt_word;
    logic        w_fetch;
    logic        w_unused;

    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_is_halt_word = (ImemInstruction == HALT_WORD);
    // A real instruction is latched only when no branch, stall or sentinel pre-empts it.
    assign w_fetch        = (r_state == S_RUN) && !BranchTaken && !Stall && !w_is_halt_word;
    assign w_unused       = &{1'b0, BranchTarget[1:0]};

    assign ImemAddress     = r_pc;
    assign IfIdInstruction = r_ifid_instr;
    assign IfIdPCPlus4     = r_ifid_pc4;
    assign IfIdValid       = r_ifid_valid;
    assign Running         = r_running;
    assign Halted          = r_halted;

    // Fetch state machine: PC, IF/ID register and registered state decodes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_ifid_instr <= 32'h0000_0000;
            r_ifid_pc4   <= 32'h0000_0000;
            r_ifid_valid <= 1'b0;
            r_running    <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                        r_halted  <= 1'b0;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (BranchTaken) begin
                        r_pc         <= {BranchTarget[31:2], 2'b00};
                        r_ifid_instr <= 32'h0000_0000;
                        r_ifid_valid <= 1'b0;
                    end else if (Stall) begin
                        r_pc         <= r_pc;
                    end else if (w_is_halt_word) begin
                        r_ifid_instr <= 32'h0000_0000;
                        r_ifid_valid <= 1'b0;
                        r_state      <= S_HALT;
                        r_running    <= 1'b0;
                        r_halted     <= 1'b1;
                    end else begin
                        r_ifid_instr <= ImemInstruction;
                        r_ifid_pc4   <= w_pc_plus4;
                        r_ifid_valid <= 1'b1;
                        // The last word is still delivered; only then does fetch stop.
                        if (r_pc == ADDR_LIMIT) begin
                            r_state   <= S_HALT;
                            r_running <= 1'b0;
                            r_halted  <= 1'b1;
                        end else begin
                            r_pc      <= w_pc_plus4;
                        end
                    end
                end
                S_HALT: begin
                    r_ifid_valid <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_ifid_valid <= 1'b0;
                    r_running    <= 1'b0;
                    r_halted     <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_fetch_cnt;

    assign CycleCount = r_cycle_cnt;
    assign FetchCount = r_fetch_cnt;

    // Free-running wrap-around counters of RUN edges and valid IF/ID latches.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cycle_cnt <= 32'd0;
            r_fetch_cnt <= 32'd0;
        end else begin
            if (r_state == S_RUN) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end else begin
                r_cycle_cnt <= r_cycle_cnt;
            end
            if (w_fetch) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end else begin
                r_fetch_cnt <= r_fetch_cnt;
            end
        end
    end
`endif

endmodule
